// File: rtl/rand_pkg.sv
// rand_pkg: shared LFSR definitions for the random_32 generator and rand_checker.
// Fibonacci LFSR x^32+x^22+x^2+x+1 plus the checker state encoding.
package rand_pkg;

  localparam int LFSR_W = 32;

  // Taps at bits 31, 21, 1 and 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that holds at all-ones.
// Async active-low reset, synchronous clear with priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/rand_checker.sv
// rand_checker: self-synchronising receive checker for the LFSR stream.
// Define RAND_CHK_STUCK_DETECT_EN to add the stuck-word detector and port.
module rand_checker
  import rand_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_value,
  output logic              locked,
  output logic              sync_err,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count
`ifdef RAND_CHK_STUCK_DETECT_EN
  ,
  output logic              stuck
`endif
);

  chk_state_t        r_state;
  logic [LFSR_W-1:0] r_expected;
  logic [7:0]        r_good_run;
  logic [7:0]        r_bad_run;

  logic w_match;
  logic w_is_locked;
  logic w_err_inc;
  logic w_word_inc;

  assign w_match     = (in_value == r_expected);
  assign w_is_locked = (r_state == LOCKED);
  assign w_word_inc  = in_valid && w_is_locked;
  assign w_err_inc   = w_word_inc && !w_match;

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (RESET_N),
    .clr   (clear),
    .inc   (w_err_inc),
    .value (err_count)
  );

  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst_n (RESET_N),
    .clr   (clear),
    .inc   (w_word_inc),
    .value (word_count)
  );

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= HUNT;
      r_expected <= '0;
      r_good_run <= '0;
      r_bad_run  <= '0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else if (clear) begin
      r_state    <= HUNT;
      r_expected <= '0;
      r_good_run <= '0;
      r_bad_run  <= '0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (in_valid) begin
        unique case (r_state)
          HUNT: begin
            // Zero is the LFSR lockup value and can never seed.
            if (in_value != '0) begin
              r_expected <= lfsr_next(in_value);
              r_good_run <= '0;
              r_state    <= VERIFY;
            end
          end
          VERIFY: begin
            r_expected <= lfsr_next(in_value);
            if (w_match) begin
              r_good_run <= r_good_run + 8'd1;
              if (r_good_run == 8'(LOCK_COUNT - 1)) begin
                r_state   <= LOCKED;
                r_bad_run <= '0;
                locked    <= 1'b1;
              end
            end else begin
              r_good_run <= '0;
              if (in_value == '0) begin
                r_state <= HUNT;
              end
            end
          end
          LOCKED: begin
            if (w_match) begin
              r_expected <= lfsr_next(in_value);
              r_bad_run  <= '0;
            end else begin
              // Flywheel: keep predicting from our own sequence.
              r_expected <= lfsr_next(r_expected);
              sync_err   <= 1'b1;
              r_bad_run  <= r_bad_run + 8'd1;
              if (r_bad_run == 8'(LOSS_COUNT - 1)) begin
                r_state <= HUNT;
                locked  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= HUNT;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RAND_CHK_STUCK_DETECT_EN
  logic [LFSR_W-1:0] r_last;
  logic [7:0]        r_run;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last <= '0;
      r_run  <= '0;
      stuck  <= 1'b0;
    end else if (clear) begin
      r_last <= '0;
      r_run  <= '0;
      stuck  <= 1'b0;
    end else if (in_valid) begin
      r_last <= in_value;
      if ((in_value == r_last) && (r_run != '0)) begin
        if (r_run != 8'hFF) begin
          r_run <= r_run + 8'd1;
        end
        stuck <= (r_run >= 8'd7);
      end else begin
        r_run <= 8'd1;
        stuck <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rand_checker.sv
// tb_rand_checker: scoreboard bench for rand_checker.
// Builds with or without RAND_CHK_STUCK_DETECT_EN.
module tb_rand_checker;

  logic        clk;
  logic        RESET_N;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_value;
  logic        locked;
  logic        sync_err;
  logic [15:0] err_count;
  logic [15:0] word_count;
`ifdef RAND_CHK_STUCK_DETECT_EN
  logic        stuck;
`endif

  rand_checker #(
    .LOCK_COUNT (4),
    .LOSS_COUNT (3),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .RESET_N    (RESET_N),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_value   (in_value),
    .locked     (locked),
    .sync_err   (sync_err),
    .err_count  (err_count),
    .word_count (word_count)
`ifdef RAND_CHK_STUCK_DETECT_EN
    ,
    .stuck      (stuck)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic        se;
    logic [15:0] ec;
    logic [15:0] wc;
    logic        st;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  int          m_state;
  logic [31:0] m_exp;
  int          m_good;
  int          m_bad;
  logic        m_lock;
  logic        m_serr;
  logic [15:0] m_err;
  logic [15:0] m_word;
  logic [31:0] m_last;
  int          m_run;
  logic        m_stuck;
  logic [31:0] cur;
  int          pulses;

  function automatic logic [31:0] nx(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic m_zero();
    m_state = 0;
    m_exp   = '0;
    m_good  = 0;
    m_bad   = 0;
    m_lock  = 1'b0;
    m_serr  = 1'b0;
    m_err   = '0;
    m_word  = '0;
    m_last  = '0;
    m_run   = 0;
    m_stuck = 1'b0;
  endtask

  task automatic m_step(
    input logic        v,
    input logic [31:0] val,
    input logic        clr
  );
    m_serr = 1'b0;
    if (clr) begin
      m_zero();
    end else if (v) begin
      if (val == m_last && m_run > 0) begin
        if (m_run < 255) m_run++;
      end else begin
        m_run = 1;
      end
      m_stuck = (m_run >= 8);
      m_last  = val;
      if (m_state == 0) begin
        if (val != 0) begin
          m_exp   = nx(val);
          m_good  = 0;
          m_state = 1;
        end
      end else if (m_state == 1) begin
        if (val == m_exp) begin
          m_exp = nx(val);
          m_good++;
          if (m_good == 4) begin
            m_state = 2;
            m_lock  = 1'b1;
            m_bad   = 0;
          end
        end else begin
          m_exp  = nx(val);
          m_good = 0;
          if (val == 0) m_state = 0;
        end
      end else begin
        if (m_word != 16'hFFFF) m_word++;
        if (val == m_exp) begin
          m_exp = nx(val);
          m_bad = 0;
        end else begin
          m_exp  = nx(m_exp);
          m_serr = 1'b1;
          if (m_err != 16'hFFFF) m_err++;
          m_bad++;
          if (m_bad == 3) begin
            m_state = 0;
            m_lock  = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step(
    input logic        v,
    input logic [31:0] val,
    input logic        clr
  );
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_value = val;
    clear    = clr;
    m_step(v, val, clr);
    e.lk = m_lock;
    e.se = m_serr;
    e.ec = m_err;
    e.wc = m_word;
    e.st = m_stuck;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("locked", 32'(locked), 32'(e.lk));
    chk("sync_err", 32'(sync_err), 32'(e.se));
    chk("err_count", 32'(err_count), 32'(e.ec));
    chk("word_count", 32'(word_count), 32'(e.wc));
`ifdef RAND_CHK_STUCK_DETECT_EN
    chk("stuck", 32'(stuck), 32'(e.st));
`endif
    if (sync_err) pulses++;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_lock"}, 32'(locked), 32'd0);
    chk({tag, "_serr"}, 32'(sync_err), 32'd0);
    chk({tag, "_ec"}, 32'(err_count), 32'd0);
    chk({tag, "_wc"}, 32'(word_count), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    #1;
    RESET_N = 1'b0;
    #1;
    outs_zero("rst");
    m_zero();
    @(negedge clk);
    RESET_N = 1'b1;
  endtask

  task automatic acquire(input logic [31:0] seed);
    cur = seed;
    step(1'b1, cur, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("pre_lock", 32'(locked), 32'd0);
      cur = nx(cur);
      step(1'b1, cur, 1'b0);
    end
    chk("acq_lock", 32'(locked), 32'd1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    pulses   = 0;
    RESET_N  = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    m_zero();
    #2;
    RESET_N = 1'b0;
    #2;
    outs_zero("por");
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;

    acquire(32'h71AD92C0);
    chk("acq_ec", 32'(err_count), 32'd0);
    chk("acq_wc", 32'(word_count), 32'd0);

    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      cur = nx(cur);
      step(1'b1, (i == 5) ? (cur ^ 32'h1) : cur, 1'b0);
      if (i == 3) step(1'b0, 32'hFFFF_FFFF, 1'b0);
    end
    chk("single_pulses", 32'(pulses), 32'd1);
    chk("single_ec", 32'(err_count), 32'd1);
    chk("single_wc", 32'(word_count), 32'd10);
    chk("single_lock", 32'(locked), 32'd1);
    cur = nx(cur);
    step(1'b1, cur, 1'b0);
    chk("flywheel_ok", 32'(sync_err), 32'd0);

    do_reset();
    acquire(32'h1357_9BDF);
    for (int i = 0; i < 3; i++) begin
      chk("loss_pre", 32'(locked), 32'd1);
      step(1'b1, 32'hDEADBEEF, 1'b0);
    end
    chk("loss_ec", 32'(err_count), 32'd3);
    chk("loss_lock", 32'(locked), 32'd0);
    acquire(32'h0BAD_F00D);

    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b0);
    chk("zero_lock", 32'(locked), 32'd0);
    acquire(32'hCAFE_0001);

    cur = nx(cur);
    step(1'b1, cur, 1'b1);
    outs_zero("clr");
    step(1'b1, nx(cur), 1'b0);
    chk("clr_hunt", 32'(locked), 32'd0);

    acquire(32'h2468_ACE0);
    cur = nx(cur);
    step(1'b1, cur ^ 32'h8, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    outs_zero("async");
    m_zero();
    @(negedge clk);
    RESET_N = 1'b1;
    step(1'b1, 32'h5555_AAAA, 1'b0);

`ifdef RAND_CHK_STUCK_DETECT_EN
    for (int i = 0; i < 8; i++) begin
      chk("stuck_pre", 32'(stuck), 32'd0);
      step(1'b1, 32'h12345678, 1'b0);
    end
    chk("stuck_set", 32'(stuck), 32'd1);
    step(1'b1, 32'h12345678, 1'b0);
    chk("stuck_hold", 32'(stuck), 32'd1);
    step(1'b1, 32'h12345679, 1'b0);
    chk("stuck_clr", 32'(stuck), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
